// File: rtl/light_phase_timer_if.sv
// Light/config bus between the traffic light controller side and the phase timer.
interface light_phase_timer_if #(
    parameter int CNT_W = 16
);
    logic             green_light;
    logic             yellow_light;
    logic             red_light;
    logic             sensor_raw;
    logic [CNT_W-1:0] cfg_green;
    logic [CNT_W-1:0] cfg_yellow;
    logic             load_cfg;
    logic             sensor;
    logic [CNT_W-1:0] green_downcnt;
    logic [CNT_W-1:0] yellow_downcnt;
    logic             phase_err;

    modport master (
        output green_light, yellow_light, red_light, sensor_raw,
        output cfg_green, cfg_yellow, load_cfg,
        input  sensor, green_downcnt, yellow_downcnt, phase_err
    );

    modport slave (
        input  green_light, yellow_light, red_light, sensor_raw,
        input  cfg_green, cfg_yellow, load_cfg,
        output sensor, green_downcnt, yellow_downcnt, phase_err
    );
endinterface

// File: rtl/light_phase_timer.sv
// Phase timers, programmable phase lengths, sensor debounce and light-encoding
// check for the traffic light controller. All outputs are registered.
module light_phase_timer #(
    parameter int CNT_W        = 16,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int TICK_DIV     = 1,
    parameter int DEBOUNCE     = 3
) (
    input  logic               clock,
    input  logic               reset,
    light_phase_timer_if.slave bus
);
    localparam int               PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int               DW       = $clog2(DEBOUNCE + 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0]    DB_MAX   = DW'(DEBOUNCE);
    localparam logic [CNT_W-1:0] G_RST    = CNT_W'(GREEN_TICKS);
    localparam logic [CNT_W-1:0] Y_RST    = CNT_W'(YELLOW_TICKS);

    typedef enum logic [1:0] {T_RED, T_GREEN, T_YELLOW} phase_t;

    phase_t           state_q, state_d;
    logic             entry;
    logic [CNT_W-1:0] green_len_q, green_len_d, yellow_len_q, yellow_len_d;
    logic [CNT_W-1:0] pend_g_q, pend_g_d, pend_y_q, pend_y_d;
    logic             pend_q, pend_d;
    logic [PW-1:0]    pre_q, pre_d, pre_cur;
    logic             tick;
    logic [CNT_W-1:0] green_cnt_q, green_cnt_d, yellow_cnt_q, yellow_cnt_d;
    logic [DW-1:0]    deb_q, deb_d;
    logic             sensor_q, sensor_d;
    logic             err_q, err_d;
    logic             first_q, first_d;

    // A zero length would make a phase end before it starts; force at least one tick.
    function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    // Next phase follows whichever light is high (green wins on illegal overlap).
    always_comb begin
        state_d = state_q;
        if (bus.green_light)       state_d = T_GREEN;
        else if (bus.yellow_light) state_d = T_YELLOW;
        else if (bus.red_light)    state_d = T_RED;
        entry = (state_d != state_q);
    end

    // Phase state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= T_RED;
        else       state_q <= state_d;
    end

    // Config capture/apply, prescaler, down-counters, debounce and error flag.
    always_comb begin
        pend_g_d     = pend_g_q;
        pend_y_d     = pend_y_q;
        pend_d       = pend_q;
        green_len_d  = green_len_q;
        yellow_len_d = yellow_len_q;

        // A load arriving while red is active is applied in the same cycle.
        if (bus.load_cfg) begin
            pend_g_d = clamp1(bus.cfg_green);
            pend_y_d = clamp1(bus.cfg_yellow);
            pend_d   = 1'b1;
        end
        if (pend_d && bus.red_light && state_d == T_RED) begin
            green_len_d  = pend_g_d;
            yellow_len_d = pend_y_d;
            pend_d       = 1'b0;
        end

        // Prescaler restarts on entry so the first decrement lands TICK_DIV clocks in.
        pre_cur = entry ? '0 : pre_q;
        tick    = (pre_cur == PRE_LAST);
        pre_d   = tick ? '0 : pre_cur + PW'(1);

        // Idle counters track the (possibly just updated) length so they are preloaded.
        if (state_d == T_GREEN)
            green_cnt_d = (tick && green_cnt_q != '0) ? green_cnt_q - CNT_W'(1) : green_cnt_q;
        else
            green_cnt_d = green_len_d;
        if (state_d == T_YELLOW)
            yellow_cnt_d = (tick && yellow_cnt_q != '0) ? yellow_cnt_q - CNT_W'(1) : yellow_cnt_q;
        else
            yellow_cnt_d = yellow_len_d;

        // Slow attack, fast release.
        if (bus.sensor_raw) deb_d = (deb_q == DB_MAX) ? deb_q : deb_q + DW'(1);
        else                deb_d = '0;
        sensor_d = bus.sensor_raw && (deb_d == DB_MAX);

        // The first cycle out of reset is skipped while the controller settles.
        err_d   = err_q | (!first_q &&
                  !$onehot({bus.red_light, bus.green_light, bus.yellow_light}));
        first_d = 1'b0;
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            green_len_q  <= G_RST;
            yellow_len_q <= Y_RST;
            pend_g_q     <= '0;
            pend_y_q     <= '0;
            pend_q       <= 1'b0;
            pre_q        <= '0;
            green_cnt_q  <= G_RST;
            yellow_cnt_q <= Y_RST;
            deb_q        <= '0;
            sensor_q     <= 1'b0;
            err_q        <= 1'b0;
            first_q      <= 1'b1;
        end else begin
            green_len_q  <= green_len_d;
            yellow_len_q <= yellow_len_d;
            pend_g_q     <= pend_g_d;
            pend_y_q     <= pend_y_d;
            pend_q       <= pend_d;
            pre_q        <= pre_d;
            green_cnt_q  <= green_cnt_d;
            yellow_cnt_q <= yellow_cnt_d;
            deb_q        <= deb_d;
            sensor_q     <= sensor_d;
            err_q        <= err_d;
            first_q      <= first_d;
        end
    end

    assign bus.sensor         = sensor_q;
    assign bus.green_downcnt  = green_cnt_q;
    assign bus.yellow_downcnt = yellow_cnt_q;
    assign bus.phase_err      = err_q;
endmodule

// File: tb/tb_light_phase_timer.sv
// Scoreboard bench: two timers (TICK_DIV=1 / GREEN=20 and TICK_DIV=4 / GREEN=2)
// share one light sequence produced by a registered controller model.
module tb_light_phase_timer;
    localparam int CW = 16;
    localparam int DB = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    light_phase_timer_if #(.CNT_W(CW)) bus0 ();
    light_phase_timer_if #(.CNT_W(CW)) bus1 ();

    light_phase_timer #(.CNT_W(CW), .GREEN_TICKS(20), .YELLOW_TICKS(4),
                        .TICK_DIV(1), .DEBOUNCE(DB))
        dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));
    light_phase_timer #(.CNT_W(CW), .GREEN_TICKS(2), .YELLOW_TICKS(4),
                        .TICK_DIV(4), .DEBOUNCE(DB))
        dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

    typedef struct {
        int gd0, yd0, gd1, yd1;
        bit sn0, er0, sn1, er1;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;

    // Reference model: per phase, remaining = length - elapsed ticks, floored at 0.
    int td_a[2] = '{1, 4};
    int gt_a[2] = '{20, 2};
    int glen[2], ylen[2], pgl[2], pyl[2], ph[2], k[2], gcnt[2], ycnt[2], run[2];
    bit pend[2], sens[2], err[2], first[2];

    // Stimulus knobs.
    bit rs_i, use_ctl, inj, og, oy, o_r, sr_i, ld_i;
    int cg_i, cy_i, ctl;

    function automatic int max0(int v);
        return (v < 0) ? 0 : v;
    endfunction

    task automatic model_step(int m, bit rs, bit g, bit y, bit r, bit sr, bit ld, int cg, int cy);
        int act;
        if (rs) begin
            glen[m] = gt_a[m]; ylen[m] = 4; gcnt[m] = glen[m]; ycnt[m] = ylen[m];
            pend[m] = 0; ph[m] = 0; k[m] = 0; run[m] = 0;
            sens[m] = 0; err[m] = 0; first[m] = 1;
            return;
        end
        act = g ? 1 : y ? 2 : r ? 0 : ph[m];
        if (act != ph[m]) k[m] = 0;
        else              k[m] = k[m] + 1;
        if (ld) begin
            pgl[m] = (cg == 0) ? 1 : cg;
            pyl[m] = (cy == 0) ? 1 : cy;
            pend[m] = 1;
        end
        if (pend[m] && r && act == 0) begin
            glen[m] = pgl[m]; ylen[m] = pyl[m]; pend[m] = 0;
        end
        gcnt[m] = (act == 1) ? max0(glen[m] - (k[m] + 1) / td_a[m]) : glen[m];
        ycnt[m] = (act == 2) ? max0(ylen[m] - (k[m] + 1) / td_a[m]) : ylen[m];
        run[m]  = sr ? run[m] + 1 : 0;
        sens[m] = (run[m] >= DB);
        if (!first[m] && (int'(g) + int'(y) + int'(r)) != 1) err[m] = 1;
        first[m] = 0;
        ph[m] = act;
    endtask

    // One clock of stimulus: drive inputs, advance controller and models, queue expectations.
    task automatic tick_cycle();
        bit g, y, r;
        exp_t e;
        @(negedge clock);
        if (use_ctl) begin
            g = (ctl == 1); y = (ctl == 2) || inj; r = (ctl == 0);
        end else begin
            g = og; y = oy; r = o_r;
        end
        reset = rs_i;
        bus0.green_light = g; bus0.yellow_light = y; bus0.red_light = r;
        bus1.green_light = g; bus1.yellow_light = y; bus1.red_light = r;
        bus0.sensor_raw = sr_i; bus1.sensor_raw = sr_i;
        bus0.load_cfg = ld_i;   bus1.load_cfg = ld_i;
        bus0.cfg_green = CW'(cg_i);  bus1.cfg_green = CW'(cg_i);
        bus0.cfg_yellow = CW'(cy_i); bus1.cfg_yellow = CW'(cy_i);
        // Registered controller: next light from the outputs visible this cycle.
        if (rs_i) ctl = 0;
        else if (use_ctl) begin
            case (ctl)
                0: if (sens[0]) ctl = 1;
                1: if (gcnt[0] == 0) ctl = 2;
                default: if (ycnt[0] == 0) ctl = 0;
            endcase
        end
        for (int m = 0; m < 2; m++) model_step(m, rs_i, g, y, r, sr_i, ld_i, cg_i, cy_i);
        e.gd0 = gcnt[0]; e.yd0 = ycnt[0]; e.sn0 = sens[0]; e.er0 = err[0];
        e.gd1 = gcnt[1]; e.yd1 = ycnt[1]; e.sn1 = sens[1]; e.er1 = err[1];
        exp_q.push_back(e);
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: every clock the DUTs present fresh outputs; compare against the queue head.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dut0.green_downcnt",  int'(bus0.green_downcnt),  e.gd0);
            chk("dut0.yellow_downcnt", int'(bus0.yellow_downcnt), e.yd0);
            chk("dut0.sensor",         int'(bus0.sensor),         int'(e.sn0));
            chk("dut0.phase_err",      int'(bus0.phase_err),      int'(e.er0));
            chk("dut1.green_downcnt",  int'(bus1.green_downcnt),  e.gd1);
            chk("dut1.yellow_downcnt", int'(bus1.yellow_downcnt), e.yd1);
            chk("dut1.sensor",         int'(bus1.sensor),         int'(e.sn1));
            chk("dut1.phase_err",      int'(bus1.phase_err),      int'(e.er1));
        end
    end

    task automatic wait_ctl(int want, string what);
        for (int n = 0; n < 400 && ctl != want; n++) tick_cycle();
        if (ctl != want) begin
            failures++;
            $display("FAIL timeout_%s: controller phase %0d, wanted %0d", what, ctl, want);
        end
    endtask

    initial begin
        rs_i = 1; use_ctl = 0; inj = 0; og = 0; oy = 0; o_r = 1;
        sr_i = 0; ld_i = 0; cg_i = 0; cy_i = 0; ctl = 0;
        reset = 1'b1;

        // Reset with red active, then idle.
        tick_cycle();
        rs_i = 0;
        tick_cycle();

        // Debounce: two highs are too short; three highs assert, one low releases.
        sr_i = 1; repeat (2) tick_cycle();
        sr_i = 0; repeat (2) tick_cycle();
        sr_i = 1; repeat (3) tick_cycle();
        sr_i = 0; repeat (2) tick_cycle();

        // Closed loop with sensor held; reprogram 5/0 in the middle of the first green.
        use_ctl = 1; sr_i = 1;
        for (int i = 0, loaded = 0; i < 200; i++) begin
            ld_i = 0;
            if (!loaded && ctl == 1 && i > 8) begin
                ld_i = 1; cg_i = 5; cy_i = 0; loaded = 1;
            end
            tick_cycle();
        end
        ld_i = 0;

        // Random sensor activity and length reloads, including zero lengths.
        for (int i = 0; i < 600; i++) begin
            sr_i = ($urandom_range(0, 3) != 0);
            ld_i = ($urandom_range(0, 29) == 0);
            cg_i = $urandom_range(0, 7);
            cy_i = $urandom_range(0, 7);
            tick_cycle();
        end

        // Back to long phases so the remaining events land mid-green.
        sr_i = 1; ld_i = 1; cg_i = 20; cy_i = 4;
        tick_cycle();
        ld_i = 0;
        wait_ctl(0, "red");
        wait_ctl(1, "green1");
        repeat (2) tick_cycle();
        inj = 1; tick_cycle();
        inj = 0; repeat (10) tick_cycle();
        wait_ctl(0, "red2");
        wait_ctl(1, "green2");
        repeat (4) tick_cycle();
        rs_i = 1; tick_cycle();
        rs_i = 0; repeat (40) tick_cycle();

        @(posedge clock);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
